tdm_demux4: RTL and testbench

- Time-division demultiplexer, the receive-side counterpart of the team's 4:1 mux: one serial sample stream carrying four interleaved channels in. Four parallel channel words out.
- Input samples arrive in strict slot order ch0, ch1, ch2, ch3. Slot 0 is marked by a start-of-frame flag.
- The block tracks slot position and collects a full frame in shadow registers. It presents all four channels together, plus a one-cycle frame-valid strobe.
- Sits between a serial link or TDM bus and the per-channel datapath. Flags framing errors and resynchronises automatically.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/tdm_demux4.sv | 141 ++++++++++++++
 tb/tb_tdm_demux4.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared types and constants for the TDM demultiplexer.
package tdm_pkg;

    // Number of interleaved channels carried in one frame.
    localparam int unsigned NUM_CH = 4;

    // Slot index within a frame.
    typedef logic [1:0] slot_t;

    // Framing state: HUNT waits for SOF, RUN tracks slot position.
    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam slot_t SLOT_CH0 = 2'd0;
    localparam slot_t SLOT_CH1 = 2'd1;
    localparam slot_t SLOT_CH2 = 2'd2;
    localparam slot_t SLOT_CH3 = 2'd3;

endpackage : tdm_pkg

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer: collects ch0..ch2 in shadow registers and
// publishes a full frame together with a one-cycle out_valid strobe when ch3
// arrives. Framing violations raise a one-cycle frame_err and resynchronise.
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sof,
    output logic [WIDTH-1:0] o0,
    output logic [WIDTH-1:0] o1,
    output logic [WIDTH-1:0] o2,
    output logic [WIDTH-1:0] o3,
    output logic             out_valid,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_err
);

    state_t           state_q,     state_d;
    slot_t            slot_q,      slot_d;
    logic [WIDTH-1:0] sh0_q,       sh0_d;
    logic [WIDTH-1:0] sh1_q,       sh1_d;
    logic [WIDTH-1:0] sh2_q,       sh2_d;
    logic [WIDTH-1:0] o0_q,        o0_d;
    logic [WIDTH-1:0] o1_q,        o1_d;
    logic [WIDTH-1:0] o2_q,        o2_d;
    logic [WIDTH-1:0] o3_q,        o3_d;
    logic             out_valid_q, out_valid_d;
    logic             frame_err_q, frame_err_d;

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            slot_q      <= SLOT_CH0;
            sh0_q       <= '0;
            sh1_q       <= '0;
            sh2_q       <= '0;
            o0_q        <= '0;
            o1_q        <= '0;
            o2_q        <= '0;
            o3_q        <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            sh0_q       <= sh0_d;
            sh1_q       <= sh1_d;
            sh2_q       <= sh2_d;
            o0_q        <= o0_d;
            o1_q        <= o1_d;
            o2_q        <= o2_d;
            o3_q        <= o3_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Next-state logic: slot tracking, shadow capture and frame publish.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        sh0_d       = sh0_q;
        sh1_d       = sh1_q;
        sh2_d       = sh2_q;
        o0_d        = o0_q;
        o1_d        = o1_q;
        o2_d        = o2_q;
        o3_d        = o3_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;

        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    if (in_sof) begin
                        sh0_d   = in_data;
                        slot_d  = SLOT_CH1;
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (in_sof) begin
                        // SOF at slot 0 is nominal; elsewhere it restarts the
                        // frame, dropping the partial one with an error.
                        if (slot_q != SLOT_CH0) begin
                            frame_err_d = 1'b1;
                        end
                        sh0_d  = in_data;
                        slot_d = SLOT_CH1;
                    end else begin
                        unique case (slot_q)
                            SLOT_CH0: begin
                                frame_err_d = 1'b1;
                                slot_d      = SLOT_CH0;
                                state_d     = HUNT;
                            end
                            SLOT_CH1: begin
                                sh1_d  = in_data;
                                slot_d = SLOT_CH2;
                            end
                            SLOT_CH2: begin
                                sh2_d  = in_data;
                                slot_d = SLOT_CH3;
                            end
                            SLOT_CH3: begin
                                o0_d        = sh0_q;
                                o1_d        = sh1_q;
                                o2_d        = sh2_q;
                                o3_d        = in_data;
                                out_valid_d = 1'b1;
                                slot_d      = SLOT_CH0;
                            end
                            default: ;
                        endcase
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = SLOT_CH0;
                end
            endcase
        end
    end

    assign o0        = o0_q;
    assign o1        = o1_q;
    assign o2        = o2_q;
    assign o3        = o3_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign slot      = slot_q;
    assign locked    = (state_q == RUN);

endmodule : tdm_demux4

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: nominal, gapped, early/missing SOF,
// back-to-back frames and mid-frame reset.
module tb_tdm_demux4;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_sof;
    logic [7:0] o0, o1, o2, o3;
    logic       out_valid;
    logic [1:0] slot;
    logic       locked;
    logic       frame_err;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_sof    (in_sof),
        .o0        (o0),
        .o1        (o1),
        .o2        (o2),
        .o3        (o3),
        .out_valid (out_valid),
        .slot      (slot),
        .locked    (locked),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_frame(input string tag, input logic [31:0] exp);
        chk({tag, ".o"}, {o0, o1, o2, o3}, exp);
    endtask

    // Present one sample for one clock edge; inputs stay as left.
    task automatic send(input logic [7:0] d, input logic sof);
        in_valid = 1'b1;
        in_data  = d;
        in_sof   = sof;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = 8'hXX;
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sof   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.o", {o0, o1, o2, o3}, 32'h0);
        chk("rst.ov", out_valid, 1'b0);
        chk("rst.fe", frame_err, 1'b0);
        chk("rst.slot", slot, 2'd0);
        chk("rst.lock", locked, 1'b0);
        rst = 1'b0;
        idle(1);

        // Nominal frame
        send(8'hA1, 1'b1);
        chk("nom.slot1", slot, 2'd1);
        chk("nom.lock", locked, 1'b1);
        send(8'hB2, 1'b0);
        chk("nom.slot2", slot, 2'd2);
        send(8'hC3, 1'b0);
        chk("nom.slot3", slot, 2'd3);
        chk("nom.ov_early", out_valid, 1'b0);
        chk_frame("nom.pre", 32'h0);
        send(8'hD4, 1'b0);
        chk("nom.ov", out_valid, 1'b1);
        chk_frame("nom", 32'hA1B2C3D4);
        chk("nom.slot0", slot, 2'd0);
        chk("nom.fe", frame_err, 1'b0);
        idle(1);
        chk("nom.ov_drop", out_valid, 1'b0);
        chk_frame("nom.hold", 32'hA1B2C3D4);

        // Gapped input
        send(8'h1A, 1'b1);
        idle(3);
        chk_frame("gap.hold0", 32'hA1B2C3D4);
        chk("gap.slot", slot, 2'd1);
        send(8'h2B, 1'b0);
        idle(3);
        send(8'h3C, 1'b0);
        idle(3);
        chk("gap.ov0", out_valid, 1'b0);
        chk_frame("gap.hold1", 32'hA1B2C3D4);
        send(8'h4D, 1'b0);
        chk("gap.ov", out_valid, 1'b1);
        chk_frame("gap", 32'h1A2B3C4D);
        idle(3);
        chk("gap.ov_drop", out_valid, 1'b0);

        // Early SOF
        send(8'h11, 1'b1);
        send(8'h22, 1'b0);
        send(8'h33, 1'b1);
        chk("esof.fe", frame_err, 1'b1);
        chk("esof.ov", out_valid, 1'b0);
        chk("esof.slot", slot, 2'd1);
        chk("esof.lock", locked, 1'b1);
        send(8'h44, 1'b0);
        chk("esof.fe_drop", frame_err, 1'b0);
        send(8'h55, 1'b0);
        send(8'h66, 1'b0);
        chk("esof.ov2", out_valid, 1'b1);
        chk_frame("esof", 32'h33445566);

        // Missing SOF at slot 0
        send(8'h77, 1'b0);
        chk("msof.fe", frame_err, 1'b1);
        chk("msof.ov", out_valid, 1'b0);
        chk("msof.lock", locked, 1'b0);
        chk("msof.slot", slot, 2'd0);
        chk_frame("msof.hold", 32'h33445566);
        send(8'h88, 1'b0);
        chk("msof.fe_hunt", frame_err, 1'b0);
        chk("msof.lock_hunt", locked, 1'b0);
        send(8'h99, 1'b0);
        chk("msof.slot_hunt", slot, 2'd0);
        chk_frame("msof.hold2", 32'h33445566);

        // Back-to-back frames
        send(8'h01, 1'b1);
        chk("b2b.lock", locked, 1'b1);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        send(8'h04, 1'b0);
        chk("b2b.ov1", out_valid, 1'b1);
        chk_frame("b2b.f1", 32'h01020304);
        send(8'h05, 1'b1);
        chk("b2b.ov1_drop", out_valid, 1'b0);
        chk("b2b.fe", frame_err, 1'b0);
        chk("b2b.slot", slot, 2'd1);
        send(8'h06, 1'b0);
        send(8'h07, 1'b0);
        chk("b2b.ov_mid", out_valid, 1'b0);
        chk_frame("b2b.hold", 32'h01020304);
        send(8'h08, 1'b0);
        chk("b2b.ov2", out_valid, 1'b1);
        chk_frame("b2b.f2", 32'h05060708);
        idle(1);

        // Mid-frame reset
        send(8'hEE, 1'b1);
        send(8'hF0, 1'b0);
        idle(0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_frame("mrst", 32'h0);
        chk("mrst.lock", locked, 1'b0);
        chk("mrst.slot", slot, 2'd0);
        chk("mrst.ov", out_valid, 1'b0);
        send(8'h12, 1'b0);
        chk("mrst.hunt", locked, 1'b0);
        send(8'h21, 1'b1);
        send(8'h32, 1'b0);
        send(8'h43, 1'b0);
        chk("mrst.ov_none", out_valid, 1'b0);
        chk_frame("mrst.hold", 32'h0);
        send(8'h54, 1'b0);
        chk("mrst.ov", out_valid, 1'b1);
        chk_frame("mrst.new", 32'h21324354);
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_tdm_demux4
